// File: rtl/proc_selfcheck_ctrl.sv
// Self-check controller: resets and runs the processor for a fixed number of cycles, freezes it,
// then compares architectural registers read through the regfile debug port against a table.
module proc_selfcheck_ctrl #(
    parameter int CYCLE_LIMIT = 20,
    parameter int HOLD_CYCLES = 4,
    parameter int NUM_CHECKS  = 8,
    parameter int READ_LAT    = 1,
    parameter int DATA_W      = 32,
    parameter int ERR_W       = 8,
    localparam int IDX_W      = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic              core_resetn,
    output logic              core_freeze,
    output logic [IDX_W-1:0]  exp_idx,
    input  logic [4:0]        exp_reg,
    input  logic [DATA_W-1:0] exp_val,
    output logic [4:0]        dbg_addr,
    input  logic [DATA_W-1:0] dbg_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  error_count,
    output logic [4:0]        fail_reg,
    output logic [DATA_W-1:0] fail_data
);

    localparam int CNT_MAX_A = (HOLD_CYCLES > CYCLE_LIMIT) ? HOLD_CYCLES : CYCLE_LIMIT;
    localparam int CNT_MAX   = (CNT_MAX_A > READ_LAT) ? CNT_MAX_A : READ_LAT;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_RUN,
        S_CHK_REQ,
        S_CHK_WAIT,
        S_CHK_CMP,
        S_DONE
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] exp_q;
    logic              mismatch;
    logic              last_check;
    logic [ERR_W-1:0]  err_next;

    assign mismatch   = (dbg_data !== exp_q);
    assign last_check = (exp_idx == IDX_W'(NUM_CHECKS - 1));
    assign err_next   = (&error_count) ? error_count : error_count + 1'b1;

    // Core control and result outputs are all registered; they change only on state transitions.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            exp_q       <= '0;
            core_resetn <= 1'b0;
            core_freeze <= 1'b1;
            exp_idx     <= '0;
            dbg_addr    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            error_count <= '0;
            fail_reg    <= '0;
            fail_data   <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state       <= S_HOLD;
                        cnt         <= '0;
                        core_resetn <= 1'b0;
                        core_freeze <= 1'b0;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        pass        <= 1'b0;
                        error_count <= '0;
                        fail_reg    <= '0;
                        fail_data   <= '0;
                        exp_idx     <= '0;
                    end
                end
                S_HOLD: begin
                    if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
                        state       <= S_RUN;
                        cnt         <= '0;
                        core_resetn <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    if (cnt == CNT_W'(CYCLE_LIMIT - 1)) begin
                        state       <= S_CHK_REQ;
                        cnt         <= '0;
                        core_freeze <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_CHK_REQ: begin
                    dbg_addr <= exp_reg;
                    exp_q    <= exp_val;
                    cnt      <= '0;
                    state    <= (READ_LAT == 0) ? S_CHK_CMP : S_CHK_WAIT;
                end
                S_CHK_WAIT: begin
                    if (cnt == CNT_W'(READ_LAT - 1)) begin
                        state <= S_CHK_CMP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_CHK_CMP: begin
                    // Only the first mismatch of a run is captured; the counter keeps going.
                    if (mismatch) begin
                        error_count <= err_next;
                        if (error_count == '0) begin
                            fail_reg  <= dbg_addr;
                            fail_data <= dbg_data;
                        end
                    end
                    if (last_check) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= !mismatch && (error_count == '0);
                    end else begin
                        exp_idx <= exp_idx + 1'b1;
                        state   <= S_CHK_REQ;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_proc_selfcheck_ctrl.sv
// Bench for proc_selfcheck_ctrl: three instances (read latency 1, 0, 3) share a toy core and table,
// checked every cycle against a cycle-offset model plus hand-computed result literals.
module tb_proc_selfcheck_ctrl;

    localparam int H  = 4;
    localparam int CL = 20;
    localparam int N  = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    always #5 clock = ~clock;

    logic [4:0]  tbl_reg [N];
    logic [31:0] tbl_val [N];
    logic [31:0] regs [32];
    int          pc;

    int cmp_cnt  = 0;
    int fail_cnt = 0;
    int done_n0, done_n1, done_n2;

    logic       resetn0, freeze0, busy0, done0, pass0;
    logic       resetn1, freeze1, busy1, done1, pass1;
    logic       resetn2, freeze2, busy2, done2, pass2;
    logic [2:0] idx0, idx1, idx2;
    logic [4:0] addr0, addr1, addr2, freg0, freg1, freg2;
    logic [31:0] fdata0, fdata1, fdata2, dbg0, dbg1, dbg2;
    logic [31:0] p1, p2, p3;
    logic [7:0] err0, err1;
    logic [1:0] err2;
    logic [4:0] ereg0, ereg1, ereg2;
    logic [31:0] eval0, eval1, eval2;

    assign ereg0 = tbl_reg[idx0];
    assign eval0 = tbl_val[idx0];
    assign ereg1 = tbl_reg[idx1];
    assign eval1 = tbl_val[idx1];
    assign ereg2 = tbl_reg[idx2];
    assign eval2 = tbl_val[idx2];

    proc_selfcheck_ctrl #(.READ_LAT(1)) u_dut (
        .clock(clock), .reset(reset), .start(start),
        .core_resetn(resetn0), .core_freeze(freeze0), .exp_idx(idx0),
        .exp_reg(ereg0), .exp_val(eval0), .dbg_addr(addr0), .dbg_data(dbg0),
        .busy(busy0), .done(done0), .pass(pass0), .error_count(err0),
        .fail_reg(freg0), .fail_data(fdata0)
    );

    proc_selfcheck_ctrl #(.READ_LAT(0)) u_lat0 (
        .clock(clock), .reset(reset), .start(start),
        .core_resetn(resetn1), .core_freeze(freeze1), .exp_idx(idx1),
        .exp_reg(ereg1), .exp_val(eval1), .dbg_addr(addr1), .dbg_data(dbg1),
        .busy(busy1), .done(done1), .pass(pass1), .error_count(err1),
        .fail_reg(freg1), .fail_data(fdata1)
    );

    proc_selfcheck_ctrl #(.READ_LAT(3), .ERR_W(2)) u_lat3 (
        .clock(clock), .reset(reset), .start(start),
        .core_resetn(resetn2), .core_freeze(freeze2), .exp_idx(idx2),
        .exp_reg(ereg2), .exp_val(eval2), .dbg_addr(addr2), .dbg_data(dbg2),
        .busy(busy2), .done(done2), .pass(pass2), .error_count(err2),
        .fail_reg(freg2), .fail_data(fdata2)
    );

    // Debug-port models of latency 1, 0 and 3 onto the shared register file
    always @(posedge clock) begin
        dbg0 <= regs[addr0];
        p1   <= regs[addr2];
        p2   <= p1;
        p3   <= p2;
    end
    assign dbg1 = regs[addr1];
    assign dbg2 = p3;

    // Toy core: r7 written early, r8 on the last allowed edge, r6 only if it overruns
    always @(posedge clock) begin
        if (!resetn0) begin
            pc <= 0;
            for (int r = 0; r < 32; r++) regs[r] <= 32'd0;
        end else if (!freeze0) begin
            pc <= pc + 1;
            if (pc == 3)      regs[7] <= 32'd7;
            if (pc == CL - 1) regs[8] <= 32'd8;
            if (pc == CL)     regs[6] <= 32'd99;
        end
    end

    function automatic logic [31:0] golden(input logic [4:0] r);
        return (r == 5'd7) ? 32'd7 : (r == 5'd8) ? 32'd8 : 32'd0;
    endfunction

    function automatic int rl_of(input int i);
        return (i == 0) ? 1 : (i == 1) ? 0 : 3;
    endfunction

    function automatic int errmax_of(input int i);
        return (i == 2) ? 3 : 255;
    endfunction

    function automatic int total_of(input int i);
        return 1 + H + CL + N * (2 + rl_of(i));
    endfunction

    function automatic int exp_err(input int maxv);
        int c = 0;
        for (int j = 0; j < N; j++) if (tbl_val[j] !== golden(tbl_reg[j])) c++;
        return (c > maxv) ? maxv : c;
    endfunction

    function automatic logic [4:0] exp_freg();
        for (int j = 0; j < N; j++) if (tbl_val[j] !== golden(tbl_reg[j])) return tbl_reg[j];
        return 5'd0;
    endfunction

    // Model: per instance, edges elapsed since the accepted start and a result snapshot
    int          m_k [3];
    bit          m_act [3];
    int          m_err [3];
    logic [4:0]  m_freg [3];
    logic [31:0] m_fdata [3];

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 3; i++) begin
                m_act[i] <= 1'b0;
                m_k[i]   <= 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (start && (!m_act[i] || m_k[i] >= total_of(i))) begin
                    m_act[i]   <= 1'b1;
                    m_k[i]     <= 1;
                    m_err[i]   <= exp_err(errmax_of(i));
                    m_freg[i]  <= exp_freg();
                    m_fdata[i] <= golden(exp_freg());
                end else if (m_act[i] && m_k[i] < total_of(i)) begin
                    m_k[i] <= m_k[i] + 1;
                end
            end
        end
    end

    task automatic compare_inst(input int i, input logic rn, input logic fz, input logic bz,
                                input logic dn, input logic ps, input int er,
                                input logic [4:0] fr, input logic [31:0] fd);
        logic [4:0]  act_c = {rn, fz, bz, dn, ps};
        logic [4:0]  exp_c;
        bit          res_chk = 1'b1;
        int          e_err   = 0;
        logic [4:0]  e_fr    = 5'd0;
        logic [31:0] e_fd    = 32'd0;
        int          k       = m_k[i];
        if (!reset || !m_act[i])       exp_c = 5'b01000;
        else if (k <= H)               exp_c = 5'b00100;
        else if (k <= H + CL)          exp_c = 5'b10100;
        else if (k < total_of(i)) begin
            exp_c   = 5'b11100;
            res_chk = 1'b0;
        end else begin
            exp_c = {4'b1101, m_err[i] == 0};
            e_err = m_err[i];
            e_fr  = m_freg[i];
            e_fd  = m_fdata[i];
        end
        cmp_cnt++;
        if (act_c !== exp_c) begin
            fail_cnt++;
            $display("[TB] FAIL ctrl inst%0d k=%0d: got rstn/frz/busy/done/pass=%b want %b",
                     i, k, act_c, exp_c);
        end
        if (res_chk) begin
            cmp_cnt++;
            if (er != e_err || fr !== e_fr || fd !== e_fd) begin
                fail_cnt++;
                $display("[TB] FAIL result inst%0d k=%0d: got err=%0d reg=%0d data=%0d want %0d/%0d/%0d",
                         i, k, er, fr, fd, e_err, e_fr, e_fd);
            end
        end
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("[TB] FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic load_base_table();
        for (int j = 0; j < N; j++) begin
            tbl_reg[j] = 5'(j + 1);
            tbl_val[j] = golden(5'(j + 1));
        end
    endtask

    task automatic record_done(input int n);
        if (done_n0 == 0 && done0) done_n0 = n;
        if (done_n1 == 0 && done1) done_n1 = n;
        if (done_n2 == 0 && done2) done_n2 = n;
    endtask

    // Pulses start, optionally re-pulses it at edge count pulse_at, and waits for all three done
    task automatic apply_stimulus(input int pulse_at, input bit chk_clear);
        int n;
        done_n0 = 0;
        done_n1 = 0;
        done_n2 = 0;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        n = 1;
        if (chk_clear) begin
            check_output("hold_clear_err", 32'(err0), 32'd0);
            check_output("hold_clear_freg", 32'(freg0), 32'd0);
            check_output("hold_clear_done", 32'(done0), 32'd0);
        end
        record_done(n);
        while (!(done_n0 != 0 && done_n1 != 0 && done_n2 != 0) && n < 200) begin
            if (n == pulse_at) start = 1'b1;
            @(posedge clock);
            #1 start = 1'b0;
            n++;
            record_done(n);
        end
        if (n >= 200) begin
            cmp_cnt++;
            fail_cnt++;
            $display("[TB] FAIL timeout: done not seen within %0d cycles", n);
        end
    endtask

    initial begin
        bit chk_en = 1'b0;
        load_base_table();
        #2 reset = 1'b0;
        chk_en = 1'b1;
        fork
            forever begin
                @(negedge clock);
                if (chk_en) begin
                    compare_inst(0, resetn0, freeze0, busy0, done0, pass0, int'(err0), freg0, fdata0);
                    compare_inst(1, resetn1, freeze1, busy1, done1, pass1, int'(err1), freg1, fdata1);
                    compare_inst(2, resetn2, freeze2, busy2, done2, pass2, int'(err2), freg2, fdata2);
                end
            end
        join_none

        repeat (3) @(posedge clock);
        #2 reset = 1'b1;
        @(posedge clock);
        #1;
        check_output("idle_resetn", 32'(resetn0), 32'd0);
        check_output("idle_freeze", 32'(freeze0), 32'd1);
        check_output("idle_dbg_addr", 32'(addr0), 32'd0);
        check_output("idle_exp_idx", 32'(idx0), 32'd0);

        $display("[TB] matching table");
        apply_stimulus(0, 1'b0);
        check_output("t1_latency_rl1", 32'(done_n0), 32'd49);
        check_output("t1_latency_rl0", 32'(done_n1), 32'd41);
        check_output("t1_latency_rl3", 32'(done_n2), 32'd65);
        check_output("t1_pass_rl1", 32'(pass0), 32'd1);
        check_output("t1_pass_rl0", 32'(pass1), 32'd1);
        check_output("t1_pass_rl3", 32'(pass2), 32'd1);
        check_output("t1_fail_reg", 32'(freg0), 32'd0);
        check_output("t1_core_pc", 32'(pc), 32'd20);

        $display("[TB] single mismatch on r4");
        tbl_val[3] = 32'd5;
        apply_stimulus(0, 1'b0);
        check_output("t2_err", 32'(err0), 32'd1);
        check_output("t2_fail_reg", 32'(freg0), 32'd4);
        check_output("t2_fail_data", fdata0, 32'd0);
        check_output("t2_pass", 32'(pass0), 32'd0);

        $display("[TB] three mismatches r2 r5 r8");
        load_base_table();
        tbl_val[1] = 32'd1;
        tbl_val[4] = 32'd1;
        tbl_val[7] = 32'd9;
        apply_stimulus(0, 1'b0);
        check_output("t3_err", 32'(err0), 32'd3);
        check_output("t3_fail_reg", 32'(freg0), 32'd2);

        $display("[TB] five mismatches, narrow counter saturates");
        tbl_reg[0] = 5'd7;  tbl_val[0] = 32'd1;
        tbl_reg[1] = 5'd0;  tbl_val[1] = 32'd0;
        tbl_reg[2] = 5'd2;  tbl_val[2] = 32'd1;
        tbl_reg[3] = 5'd8;  tbl_val[3] = 32'd9;
        tbl_reg[4] = 5'd5;  tbl_val[4] = 32'd1;
        tbl_reg[5] = 5'd3;  tbl_val[5] = 32'd0;
        tbl_reg[6] = 5'd1;  tbl_val[6] = 32'd0;
        tbl_reg[7] = 5'd4;  tbl_val[7] = 32'd1;
        apply_stimulus(0, 1'b0);
        check_output("t3b_err_w8", 32'(err0), 32'd5);
        check_output("t3b_err_rl0", 32'(err1), 32'd5);
        check_output("t3b_err_w2", 32'(err2), 32'd3);
        check_output("t3b_fail_reg", 32'(freg0), 32'd7);
        check_output("t3b_fail_data", fdata0, 32'd7);

        $display("[TB] rerun from done with start pulsed during run");
        load_base_table();
        apply_stimulus(10, 1'b1);
        check_output("t5_latency", 32'(done_n0), 32'd49);
        check_output("t5_pass", 32'(pass0), 32'd1);

        $display("[TB] async reset during check wait");
        tbl_reg[0] = 5'd7;
        tbl_val[0] = 32'd1;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (28) @(posedge clock);
        #3 reset = 1'b0;
        #1;
        check_output("t6_resetn", 32'(resetn0), 32'd0);
        check_output("t6_freeze", 32'(freeze0), 32'd1);
        check_output("t6_busy", 32'(busy0), 32'd0);
        check_output("t6_err", 32'(err0), 32'd0);
        check_output("t6_fail_reg", 32'(freg0), 32'd0);
        check_output("t6_dbg_addr", 32'(addr0), 32'd0);
        check_output("t6_exp_idx", 32'(idx0), 32'd0);
        @(negedge clock);
        #2 reset = 1'b1;
        @(posedge clock);
        #1;
        load_base_table();
        apply_stimulus(0, 1'b0);
        check_output("t6_restart_pass", 32'(pass0), 32'd1);
        check_output("t6_restart_latency", 32'(done_n0), 32'd49);

        @(posedge clock);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule
